// File: rtl/video_ovl_pkg.sv
// Shared types and constants for the sprite overlay engine: pixel colour,
// per-sprite motion state, background colour and sprite palette.
package video_ovl_pkg;

  localparam int COORD_W = 12;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               dir_x;  // 1 = moving right
    logic               dir_y;  // 1 = moving down
  } sprite_t;

  localparam rgb_t BG_COLOUR = 24'hFF_5A_43;

  // Element 0 is the rightmost entry.
  localparam rgb_t [7:0] SPR_PAL = {
    24'h80_80_80, 24'hFF_00_FF, 24'h00_FF_FF, 24'hFF_FF_00,
    24'h00_00_FF, 24'h00_FF_00, 24'hFF_00_00, 24'hFF_FF_FF
  };

  // 50% mix per channel; the 9-bit sum keeps the carry so >>1 never wraps.
  function automatic rgb_t blend50(input rgb_t a, input rgb_t b);
    logic [8:0] sr, sg, sb;
    sr = {1'b0, a.r} + {1'b0, b.r};
    sg = {1'b0, a.g} + {1'b0, b.g};
    sb = {1'b0, a.b} + {1'b0, b.b};
    return '{r: sr[8:1], g: sg[8:1], b: sb[8:1]};
  endfunction

endpackage

// File: rtl/sprite_motion.sv
// Position/direction state of one bouncing sprite; moves once per frame tick
// and clamps against the screen edges, reversing direction when it does.
module sprite_motion
  import video_ovl_pkg::*;
#(
  parameter int IDX      = 0,
  parameter int SCREEN_W = 1920,
  parameter int SCREEN_H = 1080,
  parameter int SPR_W    = 320,
  parameter int SPR_H    = 320,
  parameter int STEP_X   = 5,
  parameter int STEP_Y   = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cen_i,
  input  logic               move_i,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  localparam int PW     = COORD_W + 1;
  localparam int INIT_X = (IDX * 97) % (SCREEN_W - SPR_W);
  localparam int INIT_Y = (IDX * 53) % (SCREEN_H - SPR_H);

  localparam sprite_t INIT = '{
    x:     COORD_W'(INIT_X),
    y:     COORD_W'(INIT_Y),
    dir_x: (IDX % 2) == 1,
    dir_y: ((IDX / 2) % 2) == 1
  };

  sprite_t          spr_q, spr_d;
  logic [PW-1:0]    x_w, y_w;

  assign x_w = {1'b0, spr_q.x};
  assign y_w = {1'b0, spr_q.y};

  always_comb begin
    // NOTE: spr_d gets a full default before any branch, so no path leaves it unassigned and no latch is inferred.
    spr_d = spr_q;
    if (spr_q.dir_x) begin
      if (x_w + PW'(SPR_W + STEP_X) > PW'(SCREEN_W)) begin
        spr_d.x     = COORD_W'(SCREEN_W - SPR_W);
        spr_d.dir_x = 1'b0;
      end else begin
        spr_d.x = COORD_W'(x_w + PW'(STEP_X));
      end
    end else if (x_w < PW'(STEP_X)) begin
      spr_d.x     = '0;
      spr_d.dir_x = 1'b1;
    end else begin
      spr_d.x = COORD_W'(x_w - PW'(STEP_X));
    end

    if (spr_q.dir_y) begin
      if (y_w + PW'(SPR_H + STEP_Y) > PW'(SCREEN_H)) begin
        spr_d.y     = COORD_W'(SCREEN_H - SPR_H);
        spr_d.dir_y = 1'b0;
      end else begin
        spr_d.y = COORD_W'(y_w + PW'(STEP_Y));
      end
    end else if (y_w < PW'(STEP_Y)) begin
      spr_d.y     = '0;
      spr_d.dir_y = 1'b1;
    end else begin
      spr_d.y = COORD_W'(y_w - PW'(STEP_Y));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      spr_q <= INIT;
    end else if (cen_i && move_i) begin
      spr_q <= spr_d;
    end
  end

  assign x = spr_q.x;
  assign y = spr_q.y;

endmodule

// File: rtl/sprite_overlay_mux.sv
// Raster overlay of NUM_SPR bouncing rectangles onto a video stream, with
// fixed priority and a per-frame collision pulse. Define SPRITE_BLEND_EN for 50% blending.
module sprite_overlay_mux
  import video_ovl_pkg::*;
#(
  parameter int NUM_SPR  = 4,
  parameter int SCREEN_W = 1920,
  parameter int SCREEN_H = 1080,
  parameter int SPR_W    = 320,
  parameter int SPR_H    = 320,
  parameter int STEP_X   = 5,
  parameter int STEP_Y   = 5,
  parameter int CW       = 12
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cen_i,
  input  logic               vid_sel_i,
  input  logic [NUM_SPR-1:0] spr_en_i,
  input  logic               pause_i,
  input  logic [23:0]        vid_rgb_i,
  input  logic [1:0]         vh_blank_i,
  input  logic [2:0]         dvh_sync_i,
  output logic [2:0]         dvh_sync_o,
  output logic [23:0]        vid_rgb_o,
  output logic               collide_o
);

  localparam int HW = ((CW > COORD_W) ? CW : COORD_W) + 1;

  logic               hblank, vblank;
  logic               h_d, v_d, locked, ovl_flag;
  logic               h_f, h_r, v_r, v_f, tick, move;
  logic [CW-1:0]      x_reg, y_reg, x_cur;
  logic [COORD_W-1:0] spr_x [NUM_SPR];
  logic [COORD_W-1:0] spr_y [NUM_SPR];
  logic [NUM_SPR-1:0] hit;
  logic               multi, any_hit;
  rgb_t               spr_col, bg, pix;

  assign {vblank, hblank} = vh_blank_i;

  assign h_f  = ~hblank & h_d;
  assign h_r  = hblank & ~h_d;
  assign v_r  = vblank & ~v_d;
  assign v_f  = ~vblank & v_d;
  assign tick = v_r & locked;
  assign move = tick & ~pause_i;

  assign x_cur = h_f ? '0 : ((x_reg == '1) ? x_reg : x_reg + CW'(1));

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
    sprite_motion #(
      .IDX(i), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
      .SPR_W(SPR_W), .SPR_H(SPR_H), .STEP_X(STEP_X), .STEP_Y(STEP_Y)
    ) u_motion (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .cen_i  (cen_i),
      .move_i (move),
      .x      (spr_x[i]),
      .y      (spr_y[i])
    );
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      hit[i] = spr_en_i[i] & locked & ~hblank & ~vblank
             & (HW'(x_cur) >= HW'(spr_x[i])) & (HW'(x_cur) < HW'(spr_x[i]) + HW'(SPR_W))
             & (HW'(y_reg) >= HW'(spr_y[i])) & (HW'(y_reg) < HW'(spr_y[i]) + HW'(SPR_H));
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = (hit & (hit - NUM_SPR'(1))) != '0;

  // Walk from the highest index down so the lowest-index hit wins.
  always_comb begin
    spr_col = SPR_PAL[0];
    any_hit = 1'b0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit[i]) begin
        spr_col = SPR_PAL[3'(i)];
        any_hit = 1'b1;
      end
    end
  end

  assign bg = vid_sel_i ? BG_COLOUR : rgb_t'(vid_rgb_i);

`ifdef SPRITE_BLEND_EN
  assign pix = any_hit ? blend50(spr_col, bg) : bg;
`else
  assign pix = any_hit ? spr_col : bg;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_d        <= 1'b0;
      v_d        <= 1'b0;
      x_reg      <= '0;
      y_reg      <= '0;
      locked     <= 1'b0;
      ovl_flag   <= 1'b0;
      collide_o  <= 1'b0;
      dvh_sync_o <= '0;
      vid_rgb_o  <= '0;
    end else if (cen_i) begin
      h_d   <= hblank;
      v_d   <= vblank;
      x_reg <= x_cur;
      if (vblank) begin
        y_reg <= '0;
      end else if (h_r) begin
        y_reg <= y_reg + CW'(1);
      end
      if (v_f) begin
        locked <= 1'b1;
      end
      // An overlap seen on the tick cycle itself belongs to the next frame.
      collide_o  <= tick & ovl_flag;
      ovl_flag   <= (ovl_flag & ~tick) | multi;
      dvh_sync_o <= dvh_sync_i;
      vid_rgb_o  <= pix;
    end
  end

endmodule
